// File: rtl/toggle_src.sv
// toggle_src: turns a raw, bouncing, asynchronous push-button level into
// clean single-cycle toggle pulses for a downstream toggle flip-flop.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset, highest priority
//   btn_raw    raw asynchronous button level (1 = pressed)
//   t          registered toggle pulse, high one cycle per accepted event
//   btn_db     registered debounced button level
//   pulse_cnt  number of t pulses issued, wraps modulo 2^CNT_W
//
// Optional build macro TOGGLE_SRC_REPEAT_EN: while the button stays held,
// an extra t pulse is issued every REPEAT_CYCLES cycles (auto-repeat).
// Without it, exactly one pulse is produced per debounced press.
//
// The FSM state is held in the internal signal `state` (type state_t) so
// checkers can bind to it directly.
module toggle_src #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  output logic             t,
  output logic             btn_db,
  output logic [CNT_W-1:0] pulse_cnt
);

  // Debounce counter only ever needs to hold values up to DB_CYCLES-1.
  localparam int DCW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 2 || DB_CYCLES > 65535 ||
      REPEAT_CYCLES < 2 || CNT_W < 1) begin : g_bad_param
    $error("toggle_src: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DCW-1:0]         dcnt, dcnt_n;
  logic                   db_n;
  logic                   pulse;

`ifdef TOGGLE_SRC_REPEAT_EN
  localparam int RCW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);
  logic [RCW-1:0] rcnt, rcnt_n;
`endif

  // Last synchronizer stage is the only copy of the button the FSM sees.
  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state     <= IDLE;
      dcnt      <= '0;
      btn_db    <= 1'b0;
      t         <= 1'b0;
      pulse_cnt <= '0;
`ifdef TOGGLE_SRC_REPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      state     <= state_n;
      dcnt      <= dcnt_n;
      btn_db    <= db_n;
      t         <= pulse;
      pulse_cnt <= pulse ? pulse_cnt + 1'b1 : pulse_cnt;
`ifdef TOGGLE_SRC_REPEAT_EN
      rcnt      <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    db_n    = btn_db;
    pulse   = 1'b0;
`ifdef TOGGLE_SRC_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          dcnt_n  = DCW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          // Bounce: high run too short, drop it without a pulse.
          state_n = IDLE;
          dcnt_n  = '0;
        end else if (dcnt == DB_LAST) begin
          state_n = PRESSED;
          dcnt_n  = '0;
          db_n    = 1'b1;
          pulse   = 1'b1;
`ifdef TOGGLE_SRC_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          // Leaving PRESSED wins over a coincident repeat tick.
          state_n = RELEASE_WAIT;
          dcnt_n  = DCW'(1);
`ifdef TOGGLE_SRC_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else begin
`ifdef TOGGLE_SRC_REPEAT_EN
          if (rcnt == REP_LAST) begin
            pulse  = 1'b1;
            rcnt_n = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: back to PRESSED, no new pulse.
          state_n = PRESSED;
          dcnt_n  = '0;
`ifdef TOGGLE_SRC_REPEAT_EN
          rcnt_n  = '0;
`endif
        end else if (dcnt == DB_LAST) begin
          state_n = IDLE;
          dcnt_n  = '0;
          db_n    = 1'b0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        dcnt_n  = '0;
        db_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_toggle_src.sv
// tb_toggle_src: directed bench for toggle_src (SYNC_STAGES=2, DB_CYCLES=4,
// REPEAT_CYCLES=8, CNT_W=2 so the counter wrap is reachable quickly).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. one step after each edge.
module tb_toggle_src;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_raw;
  logic             t;
  logic             btn_db;
  logic [CNT_W-1:0] pulse_cnt;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  toggle_src #(
    .SYNC_STAGES  (2),
    .DB_CYCLES    (4),
    .REPEAT_CYCLES(8),
    .CNT_W        (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .t        (t),
    .btn_db   (btn_db),
    .pulse_cnt(pulse_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_t, input logic exp_db);
    chk({tag, "_t"}, {7'd0, t}, {7'd0, exp_t});
    chk({tag, "_db"}, {7'd0, btn_db}, {7'd0, exp_db});
    chk({tag, "_cnt"}, {6'd0, pulse_cnt}, {6'd0, exp_cnt});
  endtask

  // Clean press from IDLE: first high sample at edge 1, pulse after edge 6.
  task automatic press(input string tag);
    btn_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all({tag, "_wait"}, 1'b0, 1'b0);
    end
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk_all({tag, "_pulse"}, 1'b1, 1'b1);
    step();
    chk_all({tag, "_after"}, 1'b0, 1'b1);
  endtask

  // Clean release from PRESSED: btn_db falls after edge 6.
  task automatic release_btn(input string tag);
    btn_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all({tag, "_wait"}, 1'b0, 1'b1);
    end
    step();
    chk_all({tag, "_fall"}, 1'b0, 1'b0);
  endtask

  initial begin
    // reset then idle
    rst = 1'b1;
    btn_raw = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all("idle", 1'b0, 1'b0);
    end

    // clean press and release
    press("press1");
    release_btn("rel1");

    // bounce rejection: runs of three highs separated by single lows
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 4; k++) begin
        btn_raw = (k < 3);
        step();
        chk_all("bounce", 1'b0, 1'b0);
      end
    end
    press("press2");

    // release bounce: two low cycles while pressed, then high again
    btn_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("relb_low", 1'b0, 1'b1);
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_all("relb_high", 1'b0, 1'b1);
    end
    release_btn("rel2");

    // three more presses: counter goes 3, 0, 1
    press("press3");
    release_btn("rel3");
    press("press4");
    release_btn("rel4");
    press("press5");
    release_btn("rel5");

    // reset mid-press (FSM in PRESS_WAIT), button kept high afterwards
    btn_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("mid_wait", 1'b0, 1'b0);
    end
    rst = 1'b1;
    step();
    exp_cnt = '0;
    chk_all("mid_rst", 1'b0, 1'b0);
    rst = 1'b0;
    press("press6");
    release_btn("rel6");

    // long hold: repeat pulses only with the auto-repeat build
    press("press7");
    for (int e = 8; e <= 32; e++) begin
      logic rep;
`ifdef TOGGLE_SRC_REPEAT_EN
      rep = (e == 14) || (e == 22) || (e == 30);
`else
      rep = 1'b0;
`endif
      step();
      if (rep) exp_cnt = exp_cnt + 1'b1;
      chk_all("hold", rep, 1'b1);
    end
    release_btn("rel7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
